// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the sram request arbiter: grant states and request source IDs.
package sram_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbGInst = 2'd1,
        ArbGData = 2'd2
    } arb_state_e;

    localparam logic       SrcInst  = 1'b0;
    localparam logic       SrcData  = 1'b1;
    localparam logic [1:0] SizeWord = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_arb_id_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per accepted-but-unreturned request.
module sram_req_arbiter_arb_id_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between instruction fetch and EXE data requests, routing
// responses back in issue order.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_e state_q;
    arb_state_e grant;
    logic       gnt_inst;
    logic       gnt_data;
    logic       accept;
    logic       ret_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_dout;

    // A locked grant is kept; from idle, data wins in the same cycle it asks.
    always_comb begin
        grant = state_q;
        if (state_q == ArbIdle) begin
            if (data_req) begin
                grant = ArbGData;
            end else if (inst_req) begin
                grant = ArbGInst;
            end
        end
    end

    // Outputs are forced low while reset is asserted, whatever the inputs do.
    assign gnt_inst = resetn && (grant == ArbGInst);
    assign gnt_data = resetn && (grant == ArbGData);

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (gnt_data) begin
            mem_req   = data_req & ~fifo_full;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (gnt_inst) begin
            mem_req   = inst_req & ~fifo_full;
            mem_size  = SizeWord;
            mem_addr  = inst_addr;
        end
    end

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & gnt_inst;
    assign data_addr_ok = accept & gnt_data;

    // Returns with nothing outstanding are protocol violations and are dropped.
    assign ret_valid    = resetn & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = ret_valid & (fifo_dout == SrcInst);
    assign data_data_ok = ret_valid & (fifo_dout == SrcData);
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ArbIdle;
        end else if (mem_req && !mem_addr_ok) begin
            state_q <= grant;
        end else begin
            state_q <= ArbIdle;
        end
    end

    sram_req_arbiter_arb_id_fifo #(
        .Depth (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (ret_valid),
        .din    (gnt_data ? SrcData : SrcInst),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule
